regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised general-purpose register file for the 8-bit CPU core. It generalises the register file to configurable width, depth and number of combinational read ports. It adds an input synchroniser for the data-input register, a selectable edge or level flag-capture mode, and a defined priority rule for atomic test-and-clear (ATC) on the FLAG register. The block sits between instruction decode/ALU and the GOUT/DOUT/DINP/FLAG I/O pins.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of combinational read ports
FLAG_BITS, 7, hardware-settable flag bits (1..DATA_W)
FLAG_EDGE, 1, 1 = flag set on 0->1 edge of flag_in; 0 = set while flag_in high
SYNC_STAGES, 2, synchroniser depth on din (>=1)
DINP_ADDR, 28; GOUT_ADDR, 29; DOUT_ADDR, 30; FLAG_ADDR, 31, special register addresses

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
enable  in  1  gates software writes and ATC clear
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
flag_in  in  FLAG_BITS  hardware flag events
din  in  DATA_W  asynchronous external data input
gout, dout, flag  out  DATA_W each  GOUT/DOUT/FLAG register contents
atc_req  in  1  atomic test-and-clear request
atc_bit  in  clog2(DATA_W)  FLAG bit to test
atc_out  out  1  tested bit value

Behaviour:
- Reset is asynchronous and active-low. It clears all registers, the sync chain and the flag_in history. All outputs read 0 while resetn is low. Reset mid-ATC or mid-write discards that operation.
- Write: when wr_en and enable are high, mem[wr_addr] <= wr_data on posedge. Writes to FLAG_ADDR or DINP_ADDR are ignored.
- Read: rd_data[k] = mem[rd_addr[k]] combinationally. Read-after-write is visible the cycle after the write edge.
- FLAG bits at index FLAG_BITS and above always read 0.
- Flag set (independent of enable):
  - FLAG_EDGE=1: bit i is set when flag_in[i] & ~flag_prev[i]; flag_prev is registered every cycle.
  - FLAG_EDGE=0: bit i is set whenever flag_in[i] is high.
  - Flags are sticky until ATC.
- ATC:
  - atc_out = atc_req ? flag[atc_bit] : 0, combinational, showing the pre-clear value.
  - If atc_req and enable are high, bit atc_bit clears at the next posedge.
  - If a set event hits the same bit in the same cycle, set wins and the bit stays 1 (no lost event).
  - If atc_bit >= FLAG_BITS: atc_out = 0 and nothing clears.
- DINP: din passes through SYNC_STAGES flops and then loads into mem[DINP_ADDR] every cycle, regardless of enable. Latency from din change to DINP visible = SYNC_STAGES+1 edges.
- gout/dout/flag are continuous reads of their registers.
- enable low: software writes and ATC clear are blocked; flags and DINP keep updating.

Optional Feature:
REGFILE_BYPASS_EN.
- Defined: a read port whose rd_addr equals wr_addr, while wr_en and enable are high and wr_addr is not FLAG/DINP, returns wr_data the same cycle (write-through forwarding).
- Undefined: that read port returns the old stored value until the edge.

Decomposition:
- Shared package cpu_regfile_pkg holds the special-address constants (DINP/GOUT/DOUT/FLAG) and the default DATA_W/ADDR_W. The existing cpu_definitions.vh values are mirrored there.
- One sub-module, regfile_sync, implements the SYNC_STAGES-deep DATA_W-wide synchroniser chain.
- Flag capture logic stays inline.

Test Plan:
- Reset: drive resetn low mid-write of 8'hA5 to r3 -> r3, gout, dout, flag all 8'h00; atc_out 0.
- Write/read: write 8'h3C to r5, read r5 on ports 0 and 1 -> 8'h3C the next cycle. Write 8'hFF to r31 -> flag unchanged.
- Bypass: same-cycle read of r7 while writing 8'h81 -> 8'h81 with REGFILE_BYPASS_EN, old 8'h00 without.
- Flag edge: FLAG_EDGE=1, hold flag_in[2] high 5 cycles -> flag = 8'h04. ATC bit 2 -> atc_out 1, flag 8'h00 the next cycle.
- ATC collision: flag_in[1] rises in the same cycle as ATC on bit 1 -> atc_out shows the old value, flag[1] = 1 after the edge. ATC bit 7 -> atc_out 0.
- DINP: din 8'h5A with enable=0, SYNC_STAGES=2 -> r28 reads 8'h5A exactly 3 edges later.

Source files
------------

// File: rtl/cpu_regfile_pkg.sv
// Shared register-file constants for the 8-bit CPU core (mirrors cpu_definitions.vh).
package cpu_regfile_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 5;
  localparam int REG_DINP_ADDR = 28;
  localparam int REG_GOUT_ADDR = 29;
  localparam int REG_DOUT_ADDR = 30;
  localparam int REG_FLAG_ADDR = 31;

  // Width of a bit-select into a DATA_W-wide register; never narrower than one bit.
  function automatic int atc_width(input int data_w);
    if (data_w > 1) begin
      return $clog2(data_w);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/regfile_param_if.sv
// Read/write/ATC bus between decode/ALU (master) and the register file (slave).
interface regfile_param_if import cpu_regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int ATC_W  = atc_width(DEF_DATA_W)
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     atc_req;
  logic [ATC_W-1:0]         atc_bit;
  logic                     atc_out;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, atc_req, atc_bit,
    input  rd_data, atc_out
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, atc_req, atc_bit,
    output rd_data, atc_out
  );
endinterface

// File: rtl/regfile_sync.sv
// SYNC_STAGES-deep, DATA_W-wide flop chain bringing the asynchronous din into the clk domain.
module regfile_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] stage_r [SYNC_STAGES];

  // Shift chain; stage 0 is the only flop that samples the asynchronous input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[SYNC_STAGES-1];
endmodule

// File: rtl/regfile_param.sv
// Parametrised CPU register file: combinational read ports, synchronised DINP, sticky FLAG with ATC.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on the read ports.
module regfile_param import cpu_regfile_pkg::*; #(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RD      = 2,
  parameter int FLAG_BITS   = 7,
  parameter int FLAG_EDGE   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int DINP_ADDR   = REG_DINP_ADDR,
  parameter int GOUT_ADDR   = REG_GOUT_ADDR,
  parameter int DOUT_ADDR   = REG_DOUT_ADDR,
  parameter int FLAG_ADDR   = REG_FLAG_ADDR
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  regfile_param_if.slave       bus,
  input  logic [FLAG_BITS-1:0] flag_in,
  input  logic [DATA_W-1:0]    din,
  output logic [DATA_W-1:0]    gout,
  output logic [DATA_W-1:0]    dout,
  output logic [DATA_W-1:0]    flag
);
  localparam int              DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] DINP_A = ADDR_W'(DINP_ADDR);
  localparam logic [ADDR_W-1:0] GOUT_A = ADDR_W'(GOUT_ADDR);
  localparam logic [ADDR_W-1:0] DOUT_A = ADDR_W'(DOUT_ADDR);
  localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_ADDR);

  logic [DATA_W-1:0]    mem_r [DEPTH];
  logic [FLAG_BITS-1:0] flag_prev_r;
  logic [DATA_W-1:0]    dinp_sync_s;
  logic [DATA_W-1:0]    set_s;
  logic [DATA_W-1:0]    clr_s;
  logic [DATA_W-1:0]    flag_next_s;
  logic                 wr_fire_s;
  logic                 atc_hit_s;

  regfile_sync #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (din),
    .q      (dinp_sync_s)
  );

  // resetn is folded in so forwarding cannot leak wr_data while the block is held in reset.
  assign wr_fire_s = resetn && enable && bus.wr_en &&
                     (bus.wr_addr != DINP_A) && (bus.wr_addr != FLAG_A);
  assign atc_hit_s = bus.atc_req && (int'(bus.atc_bit) < FLAG_BITS);

  // Next FLAG value: a set event in the same cycle overrides the ATC clear.
  always_comb begin
    set_s = '0;
    clr_s = '0;
    if (FLAG_EDGE != 0) begin
      set_s[FLAG_BITS-1:0] = flag_in & ~flag_prev_r;
    end else begin
      set_s[FLAG_BITS-1:0] = flag_in;
    end
    if (atc_hit_s && enable) begin
      clr_s[bus.atc_bit] = 1'b1;
    end else begin
      clr_s = '0;
    end
    flag_next_s = (mem_r[FLAG_A] & ~clr_s) | set_s;
  end

  // Register array plus the hardware-owned FLAG/DINP entries and the flag_in history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      flag_prev_r <= '0;
    end else begin
      if (wr_fire_s) begin
        mem_r[bus.wr_addr] <= bus.wr_data;
      end
      mem_r[DINP_A] <= dinp_sync_s;
      mem_r[FLAG_A] <= flag_next_s;
      flag_prev_r   <= flag_in;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    assign ra_s = bus.rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign bus.rd_data[k*DATA_W +: DATA_W] =
      (wr_fire_s && (ra_s == bus.wr_addr)) ? bus.wr_data : mem_r[ra_s];
`else
    assign bus.rd_data[k*DATA_W +: DATA_W] = mem_r[ra_s];
`endif
  end

  assign bus.atc_out = atc_hit_s ? mem_r[FLAG_A][bus.atc_bit] : 1'b0;
  assign gout        = mem_r[GOUT_A];
  assign dout        = mem_r[DOUT_A];
  assign flag        = mem_r[FLAG_A];
endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (default parameters, FLAG_EDGE=1, SYNC_STAGES=2).
module tb_regfile_param;
  logic       clk;
  logic       resetn;
  logic       enable;
  logic [6:0] flag_in;
  logic [7:0] din;
  logic [7:0] gout;
  logic [7:0] dout;
  logic [7:0] flag;
  int vectors;
  int miscompares;

  regfile_param_if #(.DATA_W(8), .ADDR_W(5), .NUM_RD(2), .ATC_W(3)) bus ();

  regfile_param dut (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (enable),
    .bus     (bus),
    .flag_in (flag_in),
    .din     (din),
    .gout    (gout),
    .dout    (dout),
    .flag    (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] port(input int k);
    return bus.rd_data[k*8 +: 8];
  endfunction

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    resetn      = 1'b1;
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 8'hA5;
    bus.atc_req = 1'b1;
    bus.atc_bit = 3'd0;
    set_rd(5'd3, 5'd3);
    #1 resetn = 1'b0;
    tick();
    vectors++; if (port(0) !== 8'h00) begin miscompares++; $display("FAIL reset_r3 got %h exp 00", port(0)); end
    vectors++; if (gout !== 8'h00) begin miscompares++; $display("FAIL reset_gout got %h exp 00", gout); end
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got %h exp 00", dout); end
    vectors++; if (flag !== 8'h00) begin miscompares++; $display("FAIL reset_flag got %h exp 00", flag); end
    vectors++; if (bus.atc_out !== 1'b0) begin miscompares++; $display("FAIL reset_atc got %b exp 0", bus.atc_out); end
    bus.wr_en   = 1'b0;
    bus.atc_req = 1'b0;
    resetn      = 1'b1;
    tick();
    vectors++; if (port(0) !== 8'h00) begin miscompares++; $display("FAIL reset_discard_r3 got %h exp 00", port(0)); end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 8'h3C);
    set_rd(5'd5, 5'd5);
    vectors++; if (port(0) !== 8'h3C) begin miscompares++; $display("FAIL wr_r5_p0 got %h exp 3c", port(0)); end
    vectors++; if (port(1) !== 8'h3C) begin miscompares++; $display("FAIL wr_r5_p1 got %h exp 3c", port(1)); end
    do_write(5'd31, 8'hFF);
    set_rd(5'd31, 5'd5);
    vectors++; if (flag !== 8'h00) begin miscompares++; $display("FAIL wr_flag_ignored got %h exp 00", flag); end
    vectors++; if (port(0) !== 8'h00) begin miscompares++; $display("FAIL rd_r31 got %h exp 00", port(0)); end
    do_write(5'd29, 8'h12);
    do_write(5'd30, 8'h34);
    vectors++; if (gout !== 8'h12) begin miscompares++; $display("FAIL gout got %h exp 12", gout); end
    vectors++; if (dout !== 8'h34) begin miscompares++; $display("FAIL dout got %h exp 34", dout); end
    enable = 1'b0;
    do_write(5'd6, 8'h77);
    enable = 1'b1;
    set_rd(5'd6, 5'd5);
    vectors++; if (port(0) !== 8'h00) begin miscompares++; $display("FAIL wr_blocked got %h exp 00", port(0)); end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 8'h81;
`else
    exp_same = 8'h00;
`endif
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 8'h81;
    set_rd(5'd7, 5'd5);
    vectors++; if (port(0) !== exp_same) begin miscompares++; $display("FAIL bypass_same got %h exp %h", port(0), exp_same); end
    vectors++; if (port(1) !== 8'h3C) begin miscompares++; $display("FAIL bypass_other got %h exp 3c", port(1)); end
    tick();
    bus.wr_en = 1'b0;
    #1;
    vectors++; if (port(0) !== 8'h81) begin miscompares++; $display("FAIL bypass_after got %h exp 81", port(0)); end
  endtask

  task automatic test_flag_edge();
    flag_in = 7'b0000100;
    for (int i = 0; i < 5; i++) tick();
    vectors++; if (flag !== 8'h04) begin miscompares++; $display("FAIL flag_edge got %h exp 04", flag); end
    bus.atc_req = 1'b1;
    bus.atc_bit = 3'd2;
    #1;
    vectors++; if (bus.atc_out !== 1'b1) begin miscompares++; $display("FAIL atc2_out got %b exp 1", bus.atc_out); end
    tick();
    bus.atc_req = 1'b0;
    vectors++; if (flag !== 8'h00) begin miscompares++; $display("FAIL atc2_clear got %h exp 00", flag); end
    tick();
    vectors++; if (flag !== 8'h00) begin miscompares++; $display("FAIL held_no_reset got %h exp 00", flag); end
    flag_in = 7'b0000000;
    tick();
  endtask

  task automatic test_atc_collision();
    flag_in     = 7'b0000010;
    bus.atc_req = 1'b1;
    bus.atc_bit = 3'd1;
    #1;
    vectors++; if (bus.atc_out !== 1'b0) begin miscompares++; $display("FAIL coll0_out got %b exp 0", bus.atc_out); end
    tick();
    vectors++; if (flag !== 8'h02) begin miscompares++; $display("FAIL coll0_flag got %h exp 02", flag); end
    flag_in     = 7'b0000000;
    bus.atc_req = 1'b0;
    tick();
    flag_in     = 7'b0000010;
    bus.atc_req = 1'b1;
    #1;
    vectors++; if (bus.atc_out !== 1'b1) begin miscompares++; $display("FAIL coll1_out got %b exp 1", bus.atc_out); end
    tick();
    vectors++; if (flag !== 8'h02) begin miscompares++; $display("FAIL coll1_flag got %h exp 02", flag); end
    flag_in     = 7'b0000000;
    bus.atc_bit = 3'd7;
    #1;
    vectors++; if (bus.atc_out !== 1'b0) begin miscompares++; $display("FAIL atc7_out got %b exp 0", bus.atc_out); end
    tick();
    vectors++; if (flag !== 8'h02) begin miscompares++; $display("FAIL atc7_flag got %h exp 02", flag); end
    enable      = 1'b0;
    bus.atc_bit = 3'd1;
    #1;
    vectors++; if (bus.atc_out !== 1'b1) begin miscompares++; $display("FAIL atc_dis_out got %b exp 1", bus.atc_out); end
    tick();
    vectors++; if (flag !== 8'h02) begin miscompares++; $display("FAIL atc_dis_flag got %h exp 02", flag); end
    enable = 1'b1;
    tick();
    bus.atc_req = 1'b0;
    vectors++; if (flag !== 8'h00) begin miscompares++; $display("FAIL atc1_clear got %h exp 00", flag); end
  endtask

  task automatic test_dinp();
    enable = 1'b0;
    set_rd(5'd28, 5'd28);
    din = 8'h5A;
    tick();
    vectors++; if (port(0) !== 8'h00) begin miscompares++; $display("FAIL dinp_e1 got %h exp 00", port(0)); end
    tick();
    vectors++; if (port(0) !== 8'h00) begin miscompares++; $display("FAIL dinp_e2 got %h exp 00", port(0)); end
    tick();
    vectors++; if (port(1) !== 8'h5A) begin miscompares++; $display("FAIL dinp_e3 got %h exp 5a", port(1)); end
    enable = 1'b1;
    do_write(5'd28, 8'hFF);
    #1;
    vectors++; if (port(0) !== 8'h5A) begin miscompares++; $display("FAIL dinp_wr_ignored got %h exp 5a", port(0)); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    enable      = 1'b1;
    flag_in     = 7'b0000000;
    din         = 8'h00;
    bus.rd_addr = 10'd0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_data = 8'h00;
    bus.atc_req = 1'b0;
    bus.atc_bit = 3'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_flag_edge();
    test_atc_collision();
    test_dinp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
